addr_parity_chk: RTL

ADDR_PARITY_CHK -- requirements
Module: addr_parity_chk

---
 rtl/addr_parity_pkg.sv | 24 ++
 rtl/xor_slice.sv | 11 +
 rtl/addr_parity_chk.sv | 128 ++++++++++++
 3 files changed

// File: rtl/addr_parity_pkg.sv
// Shared constants, stage-1 record and parity fold helper for the address parity checker.
// The record is sized for the widest supported address; narrower builds leave the top bits at zero.
package addr_parity_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 8;
  localparam int ADDR_MAX_W    = 64;
  localparam int NUM_SLICES    = 4;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_MAX_W-1:0] addr;
    logic                  par;
    logic [NUM_SLICES-1:0] partials;
  } s1_rec_t;

  // Combine the per-slice XORs with the received parity bit; odd=1 flips the sense.
  function automatic logic fold_err(input logic [NUM_SLICES-1:0] partials,
                                    input logic                  par,
                                    input logic                  odd);
    return (^partials) ^ par ^ odd;
  endfunction

endpackage

// File: rtl/xor_slice.sv
// XOR reduction of one address slice; four of these feed stage 1 of addr_parity_chk.
module xor_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] vec,
  output logic          par
);

  assign par = ^vec;

endmodule

// File: rtl/addr_parity_chk.sv
// Two-stage address parity checker with sticky error flag and saturating error counter.
// Define ADDR_PARITY_CHK_ODD_EN to check odd parity instead of even; ports are unchanged.
module addr_parity_chk
  import addr_parity_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_addr,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_addr,
  output logic             out_err,
  input  logic             clr_err,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt
);

`ifdef ADDR_PARITY_CHK_ODD_EN
  localparam logic PAR_SENSE = 1'b1;
`else
  localparam logic PAR_SENSE = 1'b0;
`endif

  localparam int SW = WIDTH / NUM_SLICES;

  if ((WIDTH % NUM_SLICES) != 0 || WIDTH < NUM_SLICES || WIDTH > ADDR_MAX_W) begin : g_bad_width
    $error("addr_parity_chk: WIDTH must be a multiple of 4 and no wider than ADDR_MAX_W");
  end

  // Handshake: a word moves across a port on a rising edge where valid && ready are both 1.
  // A producer holds valid and its data steady until that edge; ready never depends on valid.
  s1_rec_t               s1_q;
  logic                  s2_valid;
  logic [WIDTH-1:0]      s2_addr;
  logic                  s2_err;
  logic                  s2_free;
  logic                  s1_adv;
  logic                  out_fire;
  logic                  count_evt;
  logic [NUM_SLICES-1:0] part_d;
  logic                  err_flag_d;
  logic [CNT_W-1:0]      err_cnt_d;
  logic                  unused_addr_bits;

  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_q.valid && s2_free;
  assign in_ready = !s1_q.valid || s1_adv;
  assign out_fire = s2_valid && out_ready;

  for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
    xor_slice #(.SW(SW)) u_xor (
      .vec (in_addr[i*SW +: SW]),
      .par (part_d[i])
    );
  end

  // Stage 1: address, received parity and the four slice XORs.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= '0;
    end else if (in_ready) begin
      s1_q.valid <= in_valid;
      if (in_valid) begin
        s1_q.addr     <= ADDR_MAX_W'(in_addr);
        s1_q.par      <= in_par;
        s1_q.partials <= part_d;
      end
    end
  end

  // Stage 2: only reloads when its current word leaves or it is empty, so it holds under stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_err   <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_q.valid;
      if (s1_q.valid) begin
        s2_addr <= s1_q.addr[WIDTH-1:0];
        s2_err  <= fold_err(s1_q.partials, s1_q.par, PAR_SENSE);
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_addr  = s2_addr;
  assign out_err   = s2_err;

  assign unused_addr_bits = ^s1_q.addr;

  // Errors are counted once, on the word's output handshake; a coincident clear loses to it.
  assign count_evt = out_fire && s2_err;

  always_comb begin
    err_flag_d = err_flag;
    err_cnt_d  = err_cnt;
    if (count_evt && clr_err) begin
      err_flag_d = 1'b1;
      err_cnt_d  = CNT_W'(1);
    end else if (clr_err) begin
      err_flag_d = 1'b0;
      err_cnt_d  = '0;
    end else if (count_evt) begin
      err_flag_d = 1'b1;
      if (err_cnt != {CNT_W{1'b1}}) begin
        err_cnt_d = err_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else begin
      err_flag <= err_flag_d;
      err_cnt  <= err_cnt_d;
    end
  end

endmodule
